auto_gdc: RTL and testbench
===========================

# auto_gdc

Automatic garage-door controller: a three-state Moore FSM that drives the door motor up or down on an `activate` request and stops the motor when the matching end-of-travel limit switch trips. It sits between the push-button/remote input logic and the motor driver, with the two limit switches as feedback.

## Interface
Parameters:
- `MAX_TRAVEL_CYCLES`, default 1000: travel watchdog limit in clock cycles; used only when `AUTO_GDC_TIMEOUT_EN` is defined; must be ≥ 2.

Ports:
- `clk`  input  1  single system clock; all state changes on the rising edge.
- `rst`  input  1  reset; synchronous and active-low (0 = reset, sampled on the rising edge of `clk`).
- `activate`  input  1  door request, level-sampled each rising edge.
- `up_max`  input  1  upper limit switch; 1 = door fully open.
- `dn_max`  input  1  lower limit switch; 1 = door fully closed.
- `up_m`  output  1  motor-up drive, registered.
- `dn_m`  output  1  motor-down drive, registered.

## Operation
- States: IDLE, MV_UP, MV_DN. Reset state is IDLE. After reset, `up_m` = 0 and `dn_m` = 0.
- Outputs are Moore and decoded from the state register:
  - IDLE: `up_m` = 0, `dn_m` = 0.
  - MV_UP: `up_m` = 1, `dn_m` = 0.
  - MV_DN: `up_m` = 0, `dn_m` = 1.
  - `up_m` and `dn_m` are never 1 at the same time.
- IDLE transitions:
  - `activate` = 0 → stay in IDLE.
  - `activate` = 1, `up_max` = 1, `dn_max` = 0 → MV_DN.
  - `activate` = 1, `dn_max` = 1, `up_max` = 0 → MV_UP.
  - `activate` = 1, both limits = 0 (door stopped mid-travel) → MV_UP.
  - `activate` = 1, both limits = 1 (switch fault) → stay in IDLE.
- MV_UP: `up_max` = 1 → IDLE; otherwise stay. `activate` and `dn_max` are ignored.
- MV_DN: `dn_max` = 1 → IDLE; otherwise stay. `activate` and `up_max` are ignored.
- `activate` held high after arrival: the FSM spends one cycle in IDLE, then starts the opposite move, because the new limit is now asserted. This is intended auto-reverse behaviour.
- Illegal state encoding → IDLE on the next edge.

## Timing
- `activate` sampled at edge N → motor output asserts after edge N (one-cycle latency).
- Limit switch sampled high at edge N → motor output deasserts after edge N.
- Reset low at edge N → IDLE and both outputs 0 after edge N, regardless of state or inputs; reset overrides all transitions.
- Reset taken mid-move stops the motor immediately. After reset, operation resumes from IDLE.
- Inputs are assumed synchronous to `clk`. Debouncing and synchronising the inputs are outside this block.

## Configuration
- `AUTO_GDC_TIMEOUT_EN` defined:
  - A travel counter clears on entry to MV_UP or MV_DN and increments each cycle in those states.
  - When the count reaches `MAX_TRAVEL_CYCLES` - 1 without the target limit asserting, the FSM returns to IDLE (motor stopped).
  - The counter is held at 0 in IDLE and in reset.
- Not defined: no counter; a move lasts until its limit switch asserts.

## Structure
- Package `auto_gdc_pkg` holds:
  - state type `gdc_state_t`: IDLE = 2'b00, MV_UP = 2'b01, MV_DN = 2'b10;
  - default `MAX_TRAVEL_CYCLES` constant.
- Optional sub-module `auto_gdc_travel_timer`, instantiated only under `AUTO_GDC_TIMEOUT_EN`:
  - inputs: `clk`, `rst`, `run`, `clr`;
  - output: `expired`;
  - counter width = clog2(`MAX_TRAVEL_CYCLES`).

## Test plan
- Reset: `rst` = 0 for one edge with `activate` = 1 and `dn_max` = 1 → `up_m` = 0 and `dn_m` = 0 after that edge.
- Open: IDLE, `dn_max` = 1, `activate` = 1 for one cycle → `up_m` = 1 next cycle. Hold until `up_max` = 1 → `up_m` = 0 next cycle.
- Close: IDLE, `up_max` = 1, `activate` = 1 pulse → `dn_m` = 1. `dn_max` = 1 after 5 cycles → `dn_m` = 0 the cycle after.
- Ignored activate: in MV_UP, pulse `activate` 3 times → `up_m` stays 1 and `dn_m` stays 0.
- Faults: both limits = 1 with `activate` = 1 → outputs stay 0. Both limits = 0 with `activate` = 1 → `up_m` = 1.
- Timeout (macro on, `MAX_TRAVEL_CYCLES` = 8): start MV_DN with no `dn_max` → `dn_m` = 0 after 8 cycles in MV_DN. Macro off → `dn_m` remains 1.

Source files
------------

// File: rtl/auto_gdc_pkg.sv
// Shared types and defaults for the garage-door controller.
// The optional travel watchdog is enabled with AUTO_GDC_TIMEOUT_EN.
package auto_gdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10
    } gdc_state_t;

    localparam int unsigned MAX_TRAVEL_CYCLES_DEF = 1000;

    // Motor drive pattern {up_m, dn_m} for a given state; anything unknown stops the motor.
    function automatic logic [1:0] gdc_drive(input gdc_state_t s);
        case (s)
            MV_UP:   return 2'b10;
            MV_DN:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/auto_gdc_travel_timer.sv
// Travel watchdog for auto_gdc; only built when AUTO_GDC_TIMEOUT_EN is defined.
// Counts cycles spent moving and flags the last permitted cycle of a move.
`ifdef AUTO_GDC_TIMEOUT_EN
module auto_gdc_travel_timer
    import auto_gdc_pkg::*;
#(
    parameter int unsigned MAX_TRAVEL_CYCLES = MAX_TRAVEL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = (MAX_TRAVEL_CYCLES <= 2) ? 1 : $clog2(MAX_TRAVEL_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_TRAVEL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = run && (cnt == LAST);

endmodule
`endif

// File: rtl/auto_gdc.sv
// Garage-door controller: three-state Moore FSM driving the door motor between limit switches.
// Define AUTO_GDC_TIMEOUT_EN to add a travel watchdog of MAX_TRAVEL_CYCLES cycles.
module auto_gdc
    import auto_gdc_pkg::*;
#(
    parameter int unsigned MAX_TRAVEL_CYCLES = MAX_TRAVEL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic activate,
    input  logic up_max,
    input  logic dn_max,
    output logic up_m,
    output logic dn_m
);

    gdc_state_t state;
    gdc_state_t state_nxt;
    logic       moving;
    logic       tmo;

    assign moving = (state == MV_UP) || (state == MV_DN);

`ifdef AUTO_GDC_TIMEOUT_EN
    // Counter is cleared whenever the door is not moving, so every move starts from zero.
    auto_gdc_travel_timer #(
        .MAX_TRAVEL_CYCLES(MAX_TRAVEL_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (moving),
        .clr     (!moving),
        .expired (tmo)
    );
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_TRAVEL_CYCLES < 2) ^ moving;
    assign tmo        = 1'b0;
`endif

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
                if (activate) begin
                    // Both limits high is a switch fault: refuse to move.
                    if (up_max && !dn_max) state_nxt = MV_DN;
                    else if (!up_max)      state_nxt = MV_UP;
                end
            end
            MV_UP:   state_nxt = (up_max || tmo) ? IDLE : MV_UP;
            MV_DN:   state_nxt = (dn_max || tmo) ? IDLE : MV_DN;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            {up_m, dn_m} <= 2'b00;
        end else begin
            state       <= state_nxt;
            {up_m, dn_m} <= gdc_drive(state_nxt);
        end
    end

endmodule

// File: tb/tb_auto_gdc.sv
// Self-checking bench for auto_gdc: vector table plus watchdog sequences, scoreboard-compared.
`timescale 1ns/1ps
module tb_auto_gdc;

`ifdef AUTO_GDC_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic activate = 1'b0;
    logic up_max = 1'b0;
    logic dn_max = 1'b0;
    logic up_m;
    logic dn_m;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       rst_n;
        logic       act;
        logic       up;
        logic       dn;
        logic [1:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [1:0] sb[$];

    auto_gdc #(.MAX_TRAVEL_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .activate (activate),
        .up_max   (up_max),
        .dn_max   (dn_max),
        .up_m     (up_m),
        .dn_m     (dn_m)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "time limit");
    end

    // Drive one cycle of inputs, expect {up_m, dn_m} after the next rising edge.
    task automatic step(input string name, input logic r, input logic a, input logic u,
                        input logic d, input logic [1:0] exp);
        logic [1:0] want;
        logic [1:0] got;
        @(negedge clk);
        rst = r; activate = a; up_max = u; dn_max = d;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        got = {up_m, dn_m};
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got %b", name, got);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                fails++;
                $display("FAIL %s: {up_m,dn_m} got %b required %b", name, got, want);
            end
        end
    endtask

    initial begin
        // {rst, activate, up_max, dn_max, expected {up_m,dn_m}}
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 2'b00}); // reset wins over activate
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00}); // idle, closed
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 2'b10}); // open
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'b00}); // top reached
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'b01}); // close
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00}); // bottom reached
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b00}); // switch fault
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b10}); // mid-travel -> up
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b10}); // activate ignored
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 2'b10}); // dn_max ignored in MV_UP
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b10});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'b00}); // arrival, activate held
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'b01}); // auto-reverse
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b01}); // activate ignored in MV_DN
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'b01}); // up_max ignored in MV_DN
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00}); // reset mid-move
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 2'b00});

        foreach (tbl[i])
            step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].act, tbl[i].up, tbl[i].dn, tbl[i].exp);

        // Long close with no bottom limit: watchdog stops it after 8 cycles in MV_DN.
        step("tmo_dn_start", 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
        for (int i = 1; i <= 10; i++)
            step($sformatf("tmo_dn_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0,
                 (TMO && i >= 8) ? 2'b00 : 2'b01);

        // Fresh move after reset must get the full travel budget again.
        step("tmo_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step("tmo_up_start", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        for (int i = 1; i <= 9; i++)
            step($sformatf("tmo_up_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0,
                 (TMO && i >= 8) ? 2'b00 : 2'b10);

        // Limit arriving just before the watchdog still ends the move normally.
        step("lim_rst", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        step("lim_dn_start", 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
        for (int i = 1; i <= 6; i++)
            step($sformatf("lim_dn_%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        step("lim_dn_hit", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        step("lim_dn_idle", 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
